// File: rtl/bus_axi_sequencer.sv
// rtl/bus_axi_sequencer.sv - 8088 bus-cycle sequencer to AXI4-Lite or internal memory (optional: BUS_ERR_CAPTURE_EN)
module bus_axi_sequencer #(
    parameter int ADDR_TYPE_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req,
    input  logic [1:0]             a_lo,
    input  logic [31:0]            a32,
    input  logic [31:0]            d32,
    input  logic [3:0]             wstrb,
    input  logic                   is_read,
    input  logic [ADDR_TYPE_W-1:0] addr_type,
    output logic                   ready,
    output logic [7:0]             rdata,
    output logic [31:0]            m_awaddr,
    output logic [2:0]             m_awprot,
    output logic                   m_awvalid,
    input  logic                   m_awready,
    output logic [31:0]            m_wdata,
    output logic [3:0]             m_wstrb,
    output logic                   m_wvalid,
    input  logic                   m_wready,
    input  logic [1:0]             m_bresp,
    input  logic                   m_bvalid,
    output logic                   m_bready,
    output logic [31:0]            m_araddr,
    output logic [2:0]             m_arprot,
    output logic                   m_arvalid,
    input  logic                   m_arready,
    input  logic [31:0]            m_rdata,
    input  logic [1:0]             m_rresp,
    input  logic                   m_rvalid,
    output logic                   m_rready,
    output logic                   int_en,
    output logic                   int_we,
    output logic [11:0]            int_addr,
    output logic [7:0]             int_wdata,
    input  logic [7:0]             int_rdata
`ifdef BUS_ERR_CAPTURE_EN
    ,
    output logic                   err_flag,
    output logic [31:0]            err_addr,
    input  logic                   err_clr
`endif
);

    // Target encodings shared with the address converter
    localparam logic [ADDR_TYPE_W-1:0] ADDR_TYPE_NOT_OP       = ADDR_TYPE_W'(0);
    localparam logic [ADDR_TYPE_W-1:0] ADDR_TYPE_AXI          = ADDR_TYPE_W'(1);
    localparam logic [ADDR_TYPE_W-1:0] ADDR_TYPE_INTERNAL_ROM = ADDR_TYPE_W'(2);
    localparam logic [ADDR_TYPE_W-1:0] ADDR_TYPE_INTERNAL_RAM = ADDR_TYPE_W'(3);
    localparam logic [ADDR_TYPE_W-1:0] ADDR_TYPE_UNKNOWN      = ADDR_TYPE_W'(7);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WADDR   = 3'd1,
        BWAIT   = 3'd2,
        RADDR   = 3'd3,
        RWAIT   = 3'd4,
        INT     = 3'd5,
        INTWAIT = 3'd6,
        DONE    = 3'd7
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [1:0]             lat_a_lo;
    logic [31:0]            lat_a32;
    logic [31:0]            lat_d32;
    logic [3:0]             lat_wstrb;
    logic                   lat_read;
    logic [ADDR_TYPE_W-1:0] lat_type;

    logic                   accept;
    logic                   is_internal;

    assign accept      = (state == IDLE) && req;
    assign is_internal = (addr_type == ADDR_TYPE_INTERNAL_ROM) ||
                         (addr_type == ADDR_TYPE_INTERNAL_RAM);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; AXI branches watch the registered valids so each
    // channel's handshake is tracked independently inside WADDR
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (addr_type == ADDR_TYPE_AXI) begin
                        state_next = is_read ? RADDR : WADDR;
                    end else if (is_internal) begin
                        state_next = INT;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            WADDR: begin
                if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
                    state_next = BWAIT;
                end
            end
            BWAIT: begin
                if (m_bvalid) begin
                    state_next = DONE;
                end
            end
            RADDR: begin
                if (m_arready) begin
                    state_next = RWAIT;
                end
            end
            RWAIT: begin
                if (m_rvalid) begin
                    state_next = DONE;
                end
            end
            INT:     state_next = INTWAIT;
            INTWAIT: state_next = DONE;
            DONE: begin
                if (!req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs for the CPU side and the internal memory port
    always_comb begin
        ready     = (state == DONE);
        int_en    = (state == INT);
        int_we    = (state == INT) && (lat_type == ADDR_TYPE_INTERNAL_RAM) && !lat_read;
        int_addr  = lat_a32[11:0];
        int_wdata = lat_d32[7:0];
    end

    // Registered AXI valid/ready; each valid drops on its own handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_arvalid <= 1'b0;
            m_bready  <= 1'b0;
            m_rready  <= 1'b0;
        end else begin
            m_awvalid <= (state_next == WADDR) && ((state == IDLE) || (m_awvalid && !m_awready));
            m_wvalid  <= (state_next == WADDR) && ((state == IDLE) || (m_wvalid && !m_wready));
            m_arvalid <= (state_next == RADDR);
            m_bready  <= (state_next == BWAIT);
            m_rready  <= (state_next == RWAIT);
        end
    end

    // Capture the decoded request fields when a cycle is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_a_lo  <= '0;
            lat_a32   <= '0;
            lat_d32   <= '0;
            lat_wstrb <= '0;
            lat_read  <= 1'b0;
            lat_type  <= '0;
        end else if (accept) begin
            lat_a_lo  <= a_lo;
            lat_a32   <= a32;
            lat_d32   <= d32;
            lat_wstrb <= wstrb;
            lat_read  <= is_read;
            lat_type  <= addr_type;
        end
    end

    // Read byte to the CPU; holds until the next read (or unmapped cycle) completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 8'hFF;
        end else if (accept && (addr_type != ADDR_TYPE_AXI) && !is_internal) begin
            rdata <= 8'hFF;
        end else if ((state == RWAIT) && m_rvalid) begin
            rdata <= m_rdata[{lat_a_lo, 3'b000} +: 8];
        end else if ((state == INTWAIT) && lat_read) begin
            rdata <= int_rdata;
        end
    end

    assign m_awaddr = lat_a32;
    assign m_awprot = 3'b000;
    assign m_wdata  = lat_d32;
    assign m_wstrb  = lat_wstrb;
    assign m_araddr = lat_a32;
    assign m_arprot = 3'b000;

`ifdef BUS_ERR_CAPTURE_EN
    logic        err_set;
    logic [31:0] err_src;

    // Error sources: non-OKAY responses on B/R, or an unmapped target at accept
    always_comb begin
        err_set = 1'b0;
        err_src = lat_a32;
        if ((state == BWAIT) && m_bvalid && (m_bresp != 2'b00)) begin
            err_set = 1'b1;
        end
        if ((state == RWAIT) && m_rvalid && (m_rresp != 2'b00)) begin
            err_set = 1'b1;
        end
        if (accept && (addr_type == ADDR_TYPE_UNKNOWN)) begin
            err_set = 1'b1;
            err_src = a32;
        end
    end

    // Sticky error flag; only the first error address is kept, clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag <= 1'b0;
            err_addr <= '0;
        end else if (err_clr) begin
            err_flag <= 1'b0;
        end else if (err_set && !err_flag) begin
            err_flag <= 1'b1;
            err_addr <= err_src;
        end
    end
`else
    logic unused_resp;
    assign unused_resp = ^{m_bresp, m_rresp, ADDR_TYPE_NOT_OP, ADDR_TYPE_UNKNOWN};
`endif

endmodule

// File: tb/tb_bus_axi_sequencer.sv
// tb/tb_bus_axi_sequencer.sv - self-checking bench for bus_axi_sequencer
module tb_bus_axi_sequencer;

    localparam logic [2:0] T_NOP = 3'd0;
    localparam logic [2:0] T_AXI = 3'd1;
    localparam logic [2:0] T_ROM = 3'd2;
    localparam logic [2:0] T_RAM = 3'd3;
    localparam logic [2:0] T_UNK = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  a_lo = '0;
    logic [31:0] a32 = '0;
    logic [31:0] d32 = '0;
    logic [3:0]  wstrb = '0;
    logic        is_read = 1'b0;
    logic [2:0]  addr_type = '0;
    logic        ready;
    logic [7:0]  rdata;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        int_en, int_we;
    logic [11:0] int_addr;
    logic [7:0]  int_wdata;
    logic [7:0]  int_rdata = '0;
`ifdef BUS_ERR_CAPTURE_EN
    logic        err_flag;
    logic [31:0] err_addr;
    logic        err_clr = 1'b0;
`endif

    always #5 clk = ~clk;

    bus_axi_sequencer #(.ADDR_TYPE_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_lo(a_lo), .a32(a32), .d32(d32),
        .wstrb(wstrb), .is_read(is_read), .addr_type(addr_type),
        .ready(ready), .rdata(rdata),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .int_en(int_en), .int_we(int_we), .int_addr(int_addr), .int_wdata(int_wdata),
        .int_rdata(int_rdata)
`ifdef BUS_ERR_CAPTURE_EN
        , .err_flag(err_flag), .err_addr(err_addr), .err_clr(err_clr)
`endif
    );

    // AXI slave model: per-channel wait counts, response after both AW and W
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_bresp = 2'b00;
    logic [1:0]  s_rresp = 2'b00;
    int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    logic got_aw = 1'b0, got_w = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, int_cnt = 0, we_cnt = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;
    logic [7:0]  mem [0:4095];

    assign m_awready = m_awvalid && (aw_wait >= aw_dly);
    assign m_wready  = m_wvalid && (w_wait >= w_dly);
    assign m_arready = m_arvalid && (ar_wait >= ar_dly);
    assign m_bvalid  = b_pend && (b_wait >= b_dly);
    assign m_rvalid  = r_pend && (r_wait >= r_dly);
    assign m_bresp   = s_bresp;
    assign m_rresp   = s_rresp;
    assign m_rdata   = s_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        end else begin
            aw_wait <= (m_awvalid && !m_awready) ? aw_wait + 1 : 0;
            w_wait  <= (m_wvalid && !m_wready) ? w_wait + 1 : 0;
            ar_wait <= (m_arvalid && !m_arready) ? ar_wait + 1 : 0;
            if (m_awvalid && m_awready) begin
                got_aw <= 1'b1; aw_hs <= aw_hs + 1; cap_awaddr <= m_awaddr;
            end
            if (m_wvalid && m_wready) begin
                got_w <= 1'b1; w_hs <= w_hs + 1; cap_wdata <= m_wdata; cap_wstrb <= m_wstrb;
            end
            if (!b_pend && (got_aw || (m_awvalid && m_awready)) && (got_w || (m_wvalid && m_wready))) begin
                b_pend <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0;
            end
            if (b_pend && !m_bvalid) b_wait <= b_wait + 1;
            if (m_bvalid && m_bready) begin
                b_pend <= 1'b0; b_wait <= 0; b_hs <= b_hs + 1;
            end
            if (m_arvalid && m_arready) begin
                r_pend <= 1'b1; ar_hs <= ar_hs + 1; cap_araddr <= m_araddr;
            end
            if (r_pend && !m_rvalid) r_wait <= r_wait + 1;
            if (m_rvalid && m_rready) begin
                r_pend <= 1'b0; r_wait <= 0; r_hs <= r_hs + 1;
            end
        end
    end

    // Internal memory model: one-cycle read latency, fixed ROM byte at 0x200
    always @(posedge clk) begin
        if (int_en) begin
            int_cnt <= int_cnt + 1;
            if (int_we) begin
                mem[int_addr] <= int_wdata;
                we_cnt <= we_cnt + 1;
            end
            int_rdata <= (int_addr == 12'h200) ? 8'hC3 : mem[int_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  atype;
        logic        rd;
        logic [1:0]  lo;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          awd, wd, ard, bd, rdl;
        logic [31:0] srd;
        logic [7:0]  exp_rdata;
        int          exp_edges;
        int          exp_aw, exp_w, exp_b, exp_ar, exp_r, exp_int, exp_we;
    } vec_t;

    vec_t vecs [11];

    // One full CPU cycle: drive, wait for READY, hold, release, compare
    task automatic run_txn(input vec_t v, input int idx);
        int n;
        int aw0, w0, b0, ar0, r0, i0, we0;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs; i0 = int_cnt; we0 = we_cnt;
        aw_dly = v.awd; w_dly = v.wd; ar_dly = v.ard; b_dly = v.bd; r_dly = v.rdl; s_rdata = v.srd;
        @(negedge clk);
        addr_type = v.atype; is_read = v.rd; a_lo = v.lo; a32 = v.addr; d32 = v.data; wstrb = v.strb;
        req = 1'b1;
        @(negedge clk);
        n = 0;
        while (!ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d ready_seen", idx), ready, 1'b1);
        if (v.exp_edges >= 0) chk($sformatf("v%0d latency", idx), n, v.exp_edges);
        chk($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
        repeat (2) @(negedge clk);
        chk($sformatf("v%0d ready_held", idx), ready, 1'b1);
        req = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d ready_fall", idx), ready, 1'b0);
        chk($sformatf("v%0d aw_count", idx), aw_hs - aw0, v.exp_aw);
        chk($sformatf("v%0d w_count", idx), w_hs - w0, v.exp_w);
        chk($sformatf("v%0d b_count", idx), b_hs - b0, v.exp_b);
        chk($sformatf("v%0d ar_count", idx), ar_hs - ar0, v.exp_ar);
        chk($sformatf("v%0d r_count", idx), r_hs - r0, v.exp_r);
        chk($sformatf("v%0d int_en_cycles", idx), int_cnt - i0, v.exp_int);
        chk($sformatf("v%0d int_we_cycles", idx), we_cnt - we0, v.exp_we);
        if (v.exp_aw > 0) begin
            chk($sformatf("v%0d awaddr", idx), cap_awaddr, v.addr);
            chk($sformatf("v%0d wdata", idx), cap_wdata, v.data);
            chk($sformatf("v%0d wstrb", idx), cap_wstrb, v.strb);
        end
        if (v.exp_ar > 0) chk($sformatf("v%0d araddr", idx), cap_araddr, v.addr);
    endtask

    initial begin
        int n;
        int r0;
        vec_t v;
        //           type  rd lo    a32           d32           strb     aw w ar b r  slave rdata   exp  edges aw w b ar r int we
        vecs[0]  = '{T_AXI, 0, 2'd0, 32'h4000_1000, 32'h00AB_0000, 4'b0100, 2, 0, 0, 0, 0, 32'h0,        8'hFF, -1, 1, 1, 1, 0, 0, 0, 0};
        vecs[1]  = '{T_AXI, 1, 2'd3, 32'h4000_2003, 32'h0,         4'b0000, 0, 0, 0, 0, 3, 32'h1234_5678, 8'h12, -1, 0, 0, 0, 1, 1, 0, 0};
        vecs[2]  = '{T_AXI, 1, 2'd1, 32'h4000_2101, 32'h0,         4'b0000, 0, 0, 0, 0, 0, 32'hA1B2_C3D4, 8'hC3, -1, 0, 0, 0, 1, 1, 0, 0};
        vecs[3]  = '{T_AXI, 1, 2'd0, 32'h4000_2200, 32'h0,         4'b0000, 0, 0, 2, 0, 0, 32'hDEAD_BEEF, 8'hEF, -1, 0, 0, 0, 1, 1, 0, 0};
        vecs[4]  = '{T_AXI, 1, 2'd2, 32'h4000_2302, 32'h0,         4'b0000, 0, 0, 1, 0, 1, 32'h8899_AABB, 8'h99, -1, 0, 0, 0, 1, 1, 0, 0};
        vecs[5]  = '{T_AXI, 0, 2'd0, 32'h4000_3000, 32'h1122_3344, 4'b1111, 0, 3, 0, 2, 0, 32'h0,        8'h99, -1, 1, 1, 1, 0, 0, 0, 0};
        vecs[6]  = '{T_RAM, 0, 2'd3, 32'h0000_0123, 32'h0000_005A, 4'b1000, 0, 0, 0, 0, 0, 32'h0,        8'h99,  2, 0, 0, 0, 0, 0, 1, 1};
        vecs[7]  = '{T_RAM, 1, 2'd3, 32'h0000_0123, 32'h0,         4'b0000, 0, 0, 0, 0, 0, 32'h0,        8'h5A,  2, 0, 0, 0, 0, 0, 1, 0};
        vecs[8]  = '{T_ROM, 1, 2'd0, 32'h0000_0200, 32'h0,         4'b0000, 0, 0, 0, 0, 0, 32'h0,        8'hC3,  2, 0, 0, 0, 0, 0, 1, 0};
        vecs[9]  = '{T_UNK, 0, 2'd0, 32'h0000_0F00, 32'h0000_0077, 4'b0001, 0, 0, 0, 0, 0, 32'h0,        8'hFF,  0, 0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{T_NOP, 1, 2'd0, 32'h0000_0E00, 32'h0,         4'b0000, 0, 0, 0, 0, 0, 32'h0,        8'hFF,  0, 0, 0, 0, 0, 0, 0, 0};

        repeat (3) @(negedge clk);
        chk("reset ready", ready, 1'b0);
        chk("reset rdata", rdata, 8'hFF);
        chk("reset valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
        chk("reset int", {int_en, int_we}, 2'b0);
        chk("prot tie", {m_awprot, m_arprot}, 6'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_txn(vecs[i], i);

        // Reset while a read address is outstanding
        run_txn(vecs[7], 11);
        ar_dly = 20;
        @(negedge clk);
        addr_type = T_AXI; is_read = 1'b1; a_lo = 2'd0; a32 = 32'h4000_4000; req = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst arvalid_before", m_arvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
        chk("rst ready", ready, 1'b0);
        chk("rst rdata", rdata, 8'hFF);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(vecs[2], 12);

        // req dropped before the cycle completes: finish, one DONE cycle, then IDLE
        r0 = r_hs;
        ar_dly = 0; r_dly = 4; s_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        addr_type = T_AXI; is_read = 1'b1; a_lo = 2'd2; a32 = 32'h4000_5002; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (!ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drop ready_seen", ready, 1'b1);
        chk("drop rdata", rdata, 8'hFE);
        @(negedge clk);
        chk("drop ready_one_cycle", ready, 1'b0);
        chk("drop r_count", r_hs - r0, 1);

`ifdef BUS_ERR_CAPTURE_EN
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err cleared", err_flag, 1'b0);
        s_bresp = 2'b10;
        v = vecs[0]; v.a32 = 32'h4000_A000;
        run_txn(v, 20);
        chk("err A flag", err_flag, 1'b1);
        chk("err A addr", err_addr, 32'h4000_A000);
        v.a32 = 32'h4000_B000;
        run_txn(v, 21);
        chk("err B keeps A", err_addr, 32'h4000_A000);
        err_clr = 1'b1;
        v.a32 = 32'h4000_C000;
        run_txn(v, 22);
        chk("err clr priority", err_flag, 1'b0);
        err_clr = 1'b0;
        s_bresp = 2'b00;
        run_txn(vecs[9], 23);
        chk("err unknown flag", err_flag, 1'b1);
        chk("err unknown addr", err_addr, 32'h0000_0F00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
